sobel_stream: RTL and testbench

Streaming, parametrised Sobel edge detector. It accepts one raster-order pixel per handshake and produces the gradient magnitude for every interior pixel of the frame, either saturated or thresholded. Two internal line buffers replace the testbench-side 3x3 window extraction, so a frame can be streamed straight from a source to an edge file or frame sink. The output stream is one row and one column shorter on every side of the frame: (IMG_ROWS-2)*(IMG_COLS-2) results per frame.

---
 rtl/sobel_stream_if.sv | 13 +
 rtl/sobel_stream.sv | 110 +++++++++++
 tb/tb_sobel_stream.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_stream_if.sv
// rtl/sobel_stream_if.sv - pixel/result stream handshake bundle
interface sobel_stream_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;
  logic              eol;
  logic              eof;

  modport master (output data, valid, eol, eof, input ready);
  modport slave  (input data, valid, output ready);
endinterface

// File: rtl/sobel_stream.sv
// rtl/sobel_stream.sv - streaming 3x3 Sobel edge detector with line buffers
module sobel_stream #(
  parameter int DATA_W   = 8,
  parameter int IMG_COLS = 576,
  parameter int IMG_ROWS = 436
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              mode,
  input  logic [DATA_W-1:0] thresh,
  sobel_stream_if.slave     s,
  sobel_stream_if.master    m
);
  localparam int CW = $clog2(IMG_COLS);
  localparam int RW = $clog2(IMG_ROWS);
  localparam int GW = DATA_W + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_ROWS - 1);
  localparam logic [GW-1:0] SAT_MAX  = {4'b0000, {DATA_W{1'b1}}};

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [DATA_W-1:0] lb1 [IMG_COLS];
  logic [DATA_W-1:0] lb2 [IMG_COLS];
  logic [DATA_W-1:0] z1, z2, z4, z5, z7, z8;
  logic [DATA_W-1:0] z3, z6, z9;
  logic              out_valid, out_eol, out_eof;
  logic [DATA_W-1:0] out_data;
  logic              in_xfer, produce, col_end, row_end;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]     abs_gx, abs_gy, mag;
  logic [DATA_W-1:0] result;

  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] v);
    return signed'({4'b0000, v});
  endfunction

  assign s.ready  = !out_valid || m.ready;
  assign m.data   = out_data;
  assign m.valid  = out_valid;
  assign m.eol    = out_eol;
  assign m.eof    = out_eof;

  assign in_xfer  = s.valid && s.ready;
  assign col_end  = (col == COL_LAST);
  assign row_end  = (row == ROW_LAST);
  assign produce  = in_xfer && (row >= RW'(2)) && (col >= CW'(2));

  // Right-hand window column comes straight from the line buffers and the live pixel
  assign z3 = lb2[col];
  assign z6 = lb1[col];
  assign z9 = s.data;

  always_comb begin
    gx     = (ext(z3) + (ext(z6) <<< 1) + ext(z9)) - (ext(z1) + (ext(z4) <<< 1) + ext(z7));
    gy     = (ext(z7) + (ext(z8) <<< 1) + ext(z9)) - (ext(z1) + (ext(z2) <<< 1) + ext(z3));
    abs_gx = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    abs_gy = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag    = abs_gx + abs_gy;
    if (mode) begin
      result = (mag >= {4'b0000, thresh}) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
    end else begin
      result = (mag > SAT_MAX) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col <= '0;
      row <= '0;
    end else if (in_xfer) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Buffer and window contents are never cleared; results are gated on row/col instead
  always_ff @(posedge clk) begin
    if (in_xfer) begin
      lb2[col] <= lb1[col];
      lb1[col] <= s.data;
      z1 <= z2;
      z2 <= z3;
      z4 <= z5;
      z5 <= z6;
      z7 <= z8;
      z8 <= z9;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_eol   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (produce) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_eol   <= col_end;
      out_eof   <= col_end && row_end;
    end else if (out_valid && m.ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sobel_stream.sv
// tb/tb_sobel_stream.sv - randomized self-checking bench for sobel_stream
module tb_sobel_stream;
  localparam int DW   = 8;
  localparam int COLS = 6;
  localparam int ROWS = 5;
  localparam int OC   = COLS - 2;
  localparam int NRES = (ROWS - 2) * (COLS - 2);
  localparam int MAXV = (1 << DW) - 1;

  typedef struct {
    logic [DW-1:0] data;
    logic          eol;
    logic          eof;
  } res_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          mode = 1'b0;
  logic [DW-1:0] thresh = '0;

  sobel_stream_if #(.DATA_W(DW)) s_if ();
  sobel_stream_if #(.DATA_W(DW)) m_if ();

  sobel_stream #(.DATA_W(DW), .IMG_COLS(COLS), .IMG_ROWS(ROWS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .mode    (mode),
    .thresh  (thresh),
    .s       (s_if),
    .m       (m_if)
  );

  assign s_if.eol = 1'b0;
  assign s_if.eof = 1'b0;

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   img [ROWS][COLS];
  int   res [NRES];
  res_t exp_q [$];
  res_t e;
  bit   ignore_out = 1'b0;
  bit   bp_en = 1'b0;
  bit   gap_en = 1'b0;
  bit   st_prev = 1'b0;
  logic [DW-1:0] st_data;
  logic st_eol, st_eof;
  int   kx [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  int   ky [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference: direct 3x3 convolution over the whole frame
  function automatic void model_frame(input bit md, input int th);
    for (int r = 1; r < ROWS - 1; r++) begin
      for (int c = 1; c < COLS - 1; c++) begin
        int gx = 0, gy = 0, mag, v;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            gx += kx[i][j] * img[r-1+i][c-1+j];
            gy += ky[i][j] * img[r-1+i][c-1+j];
          end
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (md) v = (mag >= th) ? MAXV : 0;
        else    v = (mag > MAXV) ? MAXV : mag;
        res[(r-1)*OC + (c-1)] = v;
      end
    end
  endfunction

  task automatic pin_row(input string name, input int i, input int a, input int b, input int c, input int d);
    check(name, res[i*OC+0], a);
    check(name, res[i*OC+1], b);
    check(name, res[i*OC+2], c);
    check(name, res[i*OC+3], d);
  endtask

  function automatic void fill(input int kind, input int v);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        case (kind)
          0: img[r][c] = v;
          1: img[r][c] = (c >= 3) ? 255 : 0;
          2: img[r][c] = (r == 2 && c == 2) ? 10 : 0;
          3: img[r][c] = (r >= 2) ? 16 : 0;
          default: img[r][c] = int'($urandom_range(0, 255));
        endcase
  endfunction

  task automatic push_pixel(input int d);
    bit ok;
    int guard;
    if (gap_en)
      while ($urandom_range(0, 3) == 0) begin
        s_if.valid = 1'b0;
        @(posedge clk); #1;
      end
    s_if.valid = 1'b1;
    s_if.data  = DW'(d);
    guard = 0;
    do begin
      @(negedge clk);
      ok = s_if.ready;
      @(posedge clk); #1;
      guard++;
    end while (!ok && guard < 1000);
    if (!ok) check("push_timeout", 0, 1);
  endtask

  task automatic send_frame(input bit md, input int th);
    int guard;
    mode   = md;
    thresh = DW'(th);
    model_frame(md, th);
    for (int k = 0; k < NRES; k++)
      exp_q.push_back('{DW'(res[k]), (k % OC) == OC - 1, k == NRES - 1});
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        push_pixel(img[r][c]);
    s_if.valid = 1'b0;
    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    m_if.ready = bp_en ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset_n || ignore_out) begin
      st_prev = 1'b0;
    end else begin
      if (m_if.valid && !m_if.ready) begin
        check("stall_s_ready", int'(s_if.ready), 0);
        if (st_prev) begin
          check("stall_data", int'(m_if.data), int'(st_data));
          check("stall_eol", int'(m_if.eol), int'(st_eol));
          check("stall_eof", int'(m_if.eof), int'(st_eof));
        end
        st_prev = 1'b1;
        st_data = m_if.data;
        st_eol  = m_if.eol;
        st_eof  = m_if.eof;
      end else begin
        st_prev = 1'b0;
      end
      if (m_if.valid && m_if.ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", int'(m_if.data), int'(e.data));
          check("out_eol", int'(m_if.eol), int'(e.eol));
          check("out_eof", int'(m_if.eof), int'(e.eof));
        end
      end
    end
  end

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", int'(m_if.valid), 0);
    check("rst_m_data", int'(m_if.data), 0);
    check("rst_m_eol", int'(m_if.eol), 0);
    check("rst_m_eof", int'(m_if.eof), 0);
    check("rst_s_ready", int'(s_if.ready), 1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    fill(0, 128);
    model_frame(0, 0);
    for (int k = 0; k < NRES; k++) check("pin_const", res[k], 0);
    send_frame(0, 0);

    fill(1, 0);
    model_frame(0, 0);
    for (int i = 0; i < ROWS - 2; i++) pin_row("pin_vstep", i, 0, 255, 255, 0);
    send_frame(0, 0);

    fill(2, 0);
    model_frame(0, 0);
    pin_row("pin_impulse_r0", 0, 20, 20, 20, 0);
    pin_row("pin_impulse_r1", 1, 20, 0, 20, 0);
    pin_row("pin_impulse_r2", 2, 20, 20, 20, 0);
    send_frame(0, 0);

    fill(3, 0);
    model_frame(1, 64);
    pin_row("pin_th64_r0", 0, 255, 255, 255, 255);
    pin_row("pin_th64_r1", 1, 255, 255, 255, 255);
    pin_row("pin_th64_r2", 2, 0, 0, 0, 0);
    send_frame(1, 64);
    model_frame(1, 65);
    for (int k = 0; k < NRES; k++) check("pin_th65", res[k], 0);
    send_frame(1, 65);

    bp_en  = 1'b1;
    gap_en = 1'b1;
    fill(1, 0);
    send_frame(0, 0);
    for (int f = 0; f < 4; f++) begin
      fill(4, 0);
      send_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
    end
    bp_en  = 1'b0;
    gap_en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      fill(4, 0);
      send_frame(1'b0, 0);
    end

    ignore_out = 1'b1;
    fill(1, 0);
    for (int p = 0; p < 17; p++) push_pixel(img[p / COLS][p % COLS]);
    s_if.valid = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_m_valid", int'(m_if.valid), 0);
    check("midrst_m_eof", int'(m_if.eof), 0);
    check("midrst_s_ready", int'(s_if.ready), 1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    ignore_out = 1'b0;
    send_frame(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
